// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes common to the controller and the
// execution stage, the FSM state encoding and the default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_ROT = 4'b1010;
   localparam logic [3:0] OP_CL1 = 4'b1011;
   localparam logic [3:0] OP_CLZ = 4'b1100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle while i_busy,
// o_product is the accumulator value after the step currently being taken.
module seq_multiplier #(
   parameter int WIDTH     = 32,
   parameter int MUL_STEPS = WIDTH
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_load,
   input  logic             i_busy,
   input  logic [WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0] i_mplier,
   output logic             o_last,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] w_step_acc;

   // Exposing the post-step sum lets the caller capture the final iteration
   // on the same edge that performs it.
   assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_product  = w_step_acc;
   assign o_last     = (r_count == CW'(MUL_STEPS - 1));

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
      end else if (i_load) begin
         r_acc    <= '0;
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
         r_count  <= '0;
      end else if (i_busy) begin
         r_acc    <= w_step_acc;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle ops complete one edge after start, MUL
// iterates in seq_multiplier while busy holds the issuing stage.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int MUL_STEPS = WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             illegal_op
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   alu_state_t       r_state, r_state_next;
   logic [WIDTH-1:0] r_result, r_result_next;
   logic             r_zero, r_zero_next;
   logic             r_done, r_done_next;
   logic             r_illegal, r_illegal_next;

   logic [WIDTH-1:0] w_op_result;
   logic             w_op_legal;
   logic [WIDTH-1:0] w_rot;
   logic [SHW-1:0]   w_shamt;
   logic             w_mul_load;
   logic             w_mul_busy;
   logic             w_mul_last;
   logic [WIDTH-1:0] w_product;

   function automatic logic [CNT_W-1:0] lead_count(input logic [WIDTH-1:0] value,
                                                   input logic bit_val);
      logic [CNT_W-1:0] n;
      logic             run;
      n   = '0;
      run = 1'b1;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (run && (value[i] == bit_val)) n = n + 1'b1;
         else run = 1'b0;
      end
      return n;
   endfunction

   assign w_shamt = B[SHW-1:0];

   // Rotate right: bit gi takes A[gi + amount], with the index wrapping mod WIDTH.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
         assign w_rot[gi] = A[SHW'(gi) + w_shamt];
      end
   endgenerate

   always_comb begin
      w_op_result = '0;
      w_op_legal  = 1'b1;
      case (ALUOp)
         OP_ADD:  w_op_result = A + B;
         OP_SUB:  w_op_result = A - B;
         OP_MUL:  w_op_result = '0;
         OP_AND:  w_op_result = A & B;
         OP_OR:   w_op_result = A | B;
         OP_SLT:  w_op_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL:  w_op_result = A << w_shamt;
         OP_SRL:  w_op_result = A >> w_shamt;
         OP_ROT:  w_op_result = w_rot;
         OP_CL1:  w_op_result = WIDTH'(lead_count(A, 1'b1));
         OP_CLZ:  w_op_result = WIDTH'(lead_count(A, 1'b0));
         default: w_op_legal  = 1'b0;
      endcase
   end

   assign w_mul_busy = (r_state == ST_MUL);

   seq_multiplier #(
      .WIDTH     (WIDTH),
      .MUL_STEPS (MUL_STEPS)
   ) u_mul (
      .i_clk     (Clk),
      .i_srst    (Rst),
      .i_load    (w_mul_load),
      .i_busy    (w_mul_busy),
      .i_mcand   (A),
      .i_mplier  (B),
      .o_last    (w_mul_last),
      .o_product (w_product)
   );

   always_comb begin
      r_state_next   = r_state;
      r_result_next  = r_result;
      r_zero_next    = r_zero;
      r_done_next    = 1'b0;
      r_illegal_next = r_illegal;
      w_mul_load     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (ALUOp == OP_MUL) begin
                  w_mul_load   = 1'b1;
                  r_state_next = ST_MUL;
               end else begin
                  r_result_next  = w_op_result;
                  r_zero_next    = (w_op_result == '0);
                  r_done_next    = 1'b1;
                  r_illegal_next = !w_op_legal;
               end
            end
         end
         ST_MUL: begin
            // start is deliberately not examined here: no queueing while busy.
            if (w_mul_last) begin
               r_result_next  = w_product;
               r_zero_next    = (w_product == '0);
               r_done_next    = 1'b1;
               r_illegal_next = 1'b0;
               r_state_next   = ST_IDLE;
            end
         end
         default: r_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= ST_IDLE;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= r_state_next;
         r_result  <= r_result_next;
         r_zero    <= r_zero_next;
         r_done    <= r_done_next;
         r_illegal <= r_illegal_next;
      end
   end

   assign result     = r_result;
   assign zero       = r_zero;
   assign busy       = w_mul_busy;
   assign done       = r_done;
   assign illegal_op = r_illegal;

endmodule
